// File: rtl/pov_pkg.sv
// pov_pkg: shared defaults, state encoding and character type for the POV string streamer.
// Rev 1.0
`default_nettype none

package pov_pkg;
    localparam int DEFAULT_CHAR_W    = 7;
    localparam int DEFAULT_NUM_CHARS = 11;
    localparam int DEFAULT_PAD_CHAR  = 0;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    typedef logic [DEFAULT_CHAR_W-1:0] char_t;
endpackage

`default_nettype wire

// File: rtl/pov_wrap_counter.sv
// pov_wrap_counter: modulo-limit counter with synchronous clear, enable and terminal-count flag.
// Rev 1.0
`default_nettype none

module pov_wrap_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             terminal
);

    assign terminal = (count == limit - WIDTH'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= terminal ? '0 : count + WIDTH'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/pov_string_streamer.sv
// pov_string_streamer: captures a packed string and serves one character per request,
// with programmable length, rotate (scroll) mode, valid/last handshake and empty/underflow status. Rev 1.0
`default_nettype none

module pov_string_streamer
    import pov_pkg::*;
#(
    parameter int                CHAR_W    = DEFAULT_CHAR_W,
    parameter int                NUM_CHARS = DEFAULT_NUM_CHARS,
    parameter logic [CHAR_W-1:0] PAD_CHAR  = CHAR_W'(DEFAULT_PAD_CHAR),
    parameter int                IDX_W     = $clog2(NUM_CHARS + 1)
) (
    input  logic                        clk,
    input  logic                        Reset,
    input  logic [0:CHAR_W*NUM_CHARS-1] StringPOV,
    input  logic [IDX_W-1:0]            Length,
    input  logic                        Rotate,
    input  logic                        LoadString,
    input  logic                        LoadNextChar,
    output logic [0:CHAR_W-1]           Char,
    output logic                        CharValid,
    output logic [IDX_W-1:0]            CharIndex,
    output logic                        Last,
    output logic                        Empty,
    output logic                        Underflow
);

    localparam logic [IDX_W-1:0] MAX_LEN = IDX_W'(NUM_CHARS);

    state_t            state;
    state_t            next_state;
    logic [CHAR_W-1:0] slots   [NUM_CHARS];
    logic [CHAR_W-1:0] shifted [NUM_CHARS];
    logic [IDX_W-1:0]  len;
    logic [IDX_W-1:0]  len_in;
    logic              rotate;
    logic              accept;
    logic [IDX_W-1:0]  ptr;
    logic              ptr_tc;

    assign len_in = (Length > MAX_LEN) ? MAX_LEN : Length;
    // A simultaneous LoadString swallows the request entirely.
    assign accept = LoadNextChar && !LoadString && (state == STREAM);
    assign Empty  = (state == IDLE);

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (LoadString)
            next_state = (len_in != '0) ? STREAM : IDLE;
        else if (accept && ptr_tc && !rotate)
            next_state = IDLE;
    end

    // Rotation re-inserts the head at slot L-1 so the scroll period equals the string length.
    always_comb begin
        for (int i = 0; i < NUM_CHARS - 1; i++) shifted[i] = slots[i+1];
        shifted[NUM_CHARS-1] = PAD_CHAR;
        for (int i = 0; i < NUM_CHARS; i++)
            if (rotate && (len == IDX_W'(i + 1))) shifted[i] = slots[0];
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < NUM_CHARS; i++) slots[i] <= '0;
            len       <= '0;
            rotate    <= 1'b0;
            Char      <= PAD_CHAR;
            CharValid <= 1'b0;
            CharIndex <= '0;
            Last      <= 1'b0;
            Underflow <= 1'b0;
        end else begin
            CharValid <= accept;
            Last      <= accept && ptr_tc;
            if (LoadString) begin
                for (int k = 0; k < NUM_CHARS; k++) slots[k] <= StringPOV[k*CHAR_W +: CHAR_W];
                len       <= len_in;
                rotate    <= Rotate;
                Underflow <= 1'b0;
            end else begin
                if (accept) begin
                    for (int i = 0; i < NUM_CHARS; i++) slots[i] <= shifted[i];
                    Char      <= slots[0];
                    CharIndex <= ptr;
                end
                if (LoadNextChar && (state == IDLE)) Underflow <= 1'b1;
            end
        end
    end

    pov_wrap_counter #(
        .WIDTH (IDX_W)
    ) u_ptr (
        .clk      (clk),
        .rst_n    (Reset),
        .clear    (LoadString),
        .enable   (accept),
        .limit    (len),
        .count    (ptr),
        .terminal (ptr_tc)
    );

endmodule

`default_nettype wire

// File: tb/tb_pov_string_streamer.sv
// tb_pov_string_streamer: directed vector table plus hand sequences for reset and async abort.
// Rev 1.0
`default_nettype none

module tb_pov_string_streamer;
    import pov_pkg::*;

    localparam int CW = 7;
    localparam int NC = 11;
    localparam int IW = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [0:CW*NC-1] str_i;
    logic [IW-1:0]   len_i;
    logic            rot_i;
    logic            ld_i;
    logic            nx_i;
    logic [0:CW-1]   ch_o;
    logic            vl_o;
    logic [IW-1:0]   ix_o;
    logic            la_o;
    logic            em_o;
    logic            uf_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pov_string_streamer dut (
        .clk          (clk),
        .Reset        (rst_n),
        .StringPOV    (str_i),
        .Length       (len_i),
        .Rotate       (rot_i),
        .LoadString   (ld_i),
        .LoadNextChar (nx_i),
        .Char         (ch_o),
        .CharValid    (vl_o),
        .CharIndex    (ix_o),
        .Last         (la_o),
        .Empty        (em_o),
        .Underflow    (uf_o)
    );

    typedef struct {
        logic             ld;
        logic             nx;
        logic [0:CW*NC-1] str;
        logic [IW-1:0]    len;
        logic             rot;
        char_t            ch;
        logic             vl;
        logic [IW-1:0]    ix;
        logic             la;
        logic             em;
        logic             uf;
    } vec_t;

    vec_t vq[$];

    function automatic logic [0:CW*NC-1] mkstr(input string s);
        logic [0:CW*NC-1] r;
        byte b;
        r = '0;
        for (int k = 0; k < s.len() && k < NC; k++) begin
            b = s[k];
            r[k*CW +: CW] = b[6:0];
        end
        return r;
    endfunction

    function automatic char_t chr(input string s, input int k);
        byte b;
        b = s[k];
        return b[6:0];
    endfunction

    function automatic void add(input logic ld, input logic nx, input logic [0:CW*NC-1] s,
                                input int len, input logic rot, input char_t ch, input logic vl,
                                input int ix, input logic la, input logic em, input logic uf);
        vec_t v;
        v.ld = ld; v.nx = nx; v.str = s; v.len = IW'(len); v.rot = rot;
        v.ch = ch; v.vl = vl; v.ix = IW'(ix); v.la = la; v.em = em; v.uf = uf;
        vq.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input char_t ch, input logic vl, input logic [IW-1:0] ix,
                           input logic la, input logic em, input logic uf);
        chk({tag, ".Char"},      32'(ch_o), 32'(ch));
        chk({tag, ".CharValid"}, 32'(vl_o), 32'(vl));
        chk({tag, ".CharIndex"}, 32'(ix_o), 32'(ix));
        chk({tag, ".Last"},      32'(la_o), 32'(la));
        chk({tag, ".Empty"},     32'(em_o), 32'(em));
        chk({tag, ".Underflow"}, 32'(uf_o), 32'(uf));
    endtask

    task automatic cyc(input logic ld, input logic nx, input logic [0:CW*NC-1] s,
                       input logic [IW-1:0] len, input logic rot);
        @(negedge clk);
        ld_i = ld; nx_i = nx; str_i = s; len_i = len; rot_i = rot;
        @(posedge clk);
        #1;
    endtask

    initial begin
        string hw, abc, alpha;
        logic [0:CW*NC-1] s_hw, s_abc, s_alpha, s_xyz, z;
        hw = "HELLOWORLD!"; abc = "ABC"; alpha = "ABCDEFGHIJK";
        s_hw = mkstr(hw); s_abc = mkstr(abc); s_alpha = mkstr(alpha); s_xyz = mkstr("XYZ");
        z = '0;

        // Reset underflow request, then one-shot full-length string
        add(0, 1, z, 0, 0, 7'h00, 0, 0, 0, 1, 1);
        add(1, 0, s_hw, 11, 0, 7'h00, 0, 0, 0, 0, 0);
        for (int i = 0; i < 11; i++)
            add(0, 1, z, 0, 0, chr(hw, i), 1, i, i == 10, i == 10, 0);
        add(0, 1, z, 0, 0, 7'h21, 0, 10, 0, 1, 1);
        // Rotate with L=3, then an idle cycle
        add(1, 0, s_abc, 3, 1, 7'h21, 0, 10, 0, 0, 0);
        for (int i = 0; i < 7; i++)
            add(0, 1, z, 0, 0, chr(abc, i % 3), 1, i % 3, (i % 3) == 2, 0, 0);
        add(0, 0, z, 0, 0, 7'h41, 0, 0, 0, 0, 0);
        // Length clamp 15 -> 11, then Length=0
        add(1, 0, s_alpha, 15, 0, 7'h41, 0, 0, 0, 0, 0);
        for (int i = 0; i < 11; i++)
            add(0, 1, z, 0, 0, chr(alpha, i), 1, i, i == 10, i == 10, 0);
        add(1, 0, s_xyz, 0, 0, 7'h4B, 0, 10, 0, 1, 0);
        add(0, 1, z, 0, 0, 7'h4B, 0, 10, 0, 1, 1);
        // LoadString wins over a simultaneous request mid-stream
        add(1, 0, s_hw, 11, 1, 7'h4B, 0, 10, 0, 0, 0);
        add(0, 1, z, 0, 0, 7'h48, 1, 0, 0, 0, 0);
        add(0, 1, z, 0, 0, 7'h45, 1, 1, 0, 0, 0);
        add(1, 1, s_abc, 3, 0, 7'h45, 0, 1, 0, 0, 0);
        add(0, 1, z, 0, 0, 7'h41, 1, 0, 0, 0, 0);
        add(0, 1, z, 0, 0, 7'h42, 1, 1, 0, 0, 0);
        add(0, 1, z, 0, 0, 7'h43, 1, 2, 1, 1, 0);
        add(0, 1, z, 0, 0, 7'h43, 0, 2, 0, 1, 1);

        rst_n = 1'b0; ld_i = 0; nx_i = 0; str_i = '0; len_i = '0; rot_i = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_all("reset", 7'h00, 0, 0, 0, 1, 0);

        foreach (vq[i]) begin
            cyc(vq[i].ld, vq[i].nx, vq[i].str, vq[i].len, vq[i].rot);
            chk_all($sformatf("vec%0d", i), vq[i].ch, vq[i].vl, vq[i].ix, vq[i].la, vq[i].em, vq[i].uf);
        end

        // Asynchronous reset in the middle of a rotation
        cyc(1, 0, s_abc, 3, 1);
        cyc(0, 1, z, 0, 0);
        cyc(0, 1, z, 0, 0);
        chk_all("prerst", 7'h42, 1, 1, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("asyncrst", 7'h00, 0, 0, 0, 1, 0);
        @(negedge clk);
        rst_n = 1'b1; nx_i = 0;
        cyc(0, 1, z, 0, 0);
        chk_all("postrst", 7'h00, 0, 0, 0, 1, 1);
        cyc(0, 0, z, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pov_string_streamer.md
Name: pov_string_streamer

Overview:
Parametrised successor to the POV string/character loader. It captures a packed string of NUM_CHARS characters, each CHAR_W bits wide, and serves one character per LoadNextChar request. It adds a programmable string length, a rotate (scroll) mode, a valid/last handshake, a character index, and empty/underflow status. It sits between the message source and the POV column/font generator.

Parameters:
CHAR_W, 7, bits per character
NUM_CHARS, 11, character slots in StringPOV
PAD_CHAR, 0, value driven on Char when no character is available
IDX_W, $clog2(NUM_CHARS+1), width of Length and CharIndex

Ports:
clk  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-low reset
StringPOV  in  [0:CHAR_W*NUM_CHARS-1]  packed string; char k occupies bits [k*CHAR_W : k*CHAR_W+CHAR_W-1] (char 0 at MSB end)
Length  in  IDX_W  number of valid chars, sampled with LoadString
Rotate  in  1  sampled with LoadString; 1 = recirculate chars (scroll), 0 = one-shot
LoadString  in  1  single-cycle pulse: capture StringPOV/Length/Rotate
LoadNextChar  in  1  single-cycle pulse: request next char
Char  out  [0:CHAR_W-1]  current character, registered
CharValid  out  1  1-cycle pulse: Char updated by an accepted request
CharIndex  out  IDX_W  position (0-based) of the char on Char
Last  out  1  asserted with CharValid when CharIndex == effective length-1
Empty  out  1  level: no chars remain in one-shot mode, or no string loaded
Underflow  out  1  sticky: request arrived while Empty

Behaviour:
- Reset low (async): shift register=0, Char=PAD_CHAR, CharValid=0, CharIndex=0, Last=0, Empty=1, Underflow=0, state=IDLE. Release is synchronous to clk.
- Effective length L = min(Length, NUM_CHARS), latched on LoadString.
- States: IDLE (nothing loaded) and STREAM (chars remaining or rotating).
  - LoadString with L>0 -> STREAM, Empty=0.
  - LoadString with L=0 -> IDLE, Empty=1.
- LoadString also clears Underflow and the read pointer. It does not change Char or CharValid.
- Request accepted in STREAM, response 1 clock after the request:
  - Char = head character (slot 0 of the shift register); CharValid=1 for exactly one cycle; CharIndex = pointer.
  - Shift register moves left by CHAR_W.
  - Rotate=0: PAD_CHAR is shifted in at the tail.
  - Rotate=1: the head char is shifted in at slot L-1, not at the physical tail, so the rotation period is L.
- Pointer and Last:
  - Pointer increments per accepted request.
  - At pointer==L-1: Last=1 with that CharValid.
  - Rotate=1: pointer wraps to 0, state stays STREAM.
  - Rotate=0: state -> IDLE, Empty=1 in the same cycle as that CharValid.
- Request while Empty/IDLE: Char unchanged, CharValid=0, Underflow=1 (sticky until LoadString or reset).
- LoadString and LoadNextChar in the same cycle: LoadString wins. The request is dropped and does not set Underflow.
- Back-to-back requests every cycle are supported at full rate.
- Reset asserted mid-stream aborts immediately to reset values.

Decomposition:
- Package pov_pkg:
  - default CHAR_W/NUM_CHARS constants
  - PAD_CHAR constant
  - state enum {IDLE, STREAM}
  - char_t typedef (CHAR_W bits)
- Sub-module pov_wrap_counter: IDX_W-wide modulo-L counter with clear, enable and terminal-count output. It drives CharIndex and Last. Everything else is inline.

Test Plan:
1. Reset low for 3 cycles, then release -> Char=0, CharValid=0, Empty=1, Underflow=0; a request sets Underflow=1 with CharValid=0.
2. Load "HELLOWORLD!" (11 ASCII chars), Length=11, Rotate=0; issue 11 requests -> Char = 0x48,0x45,...,0x21 in order, CharIndex 0..10, Last only on index 10, Empty=1 the same cycle; a 12th request sets Underflow=1.
3. Load "ABC" in slots 0-2, Length=3, Rotate=1; issue 7 requests -> A,B,C,A,B,C,A with Last on each C, Empty stays 0.
4. Length=15 with NUM_CHARS=11 -> clamps to 11: Last on index 10, no PAD output before it. Length=0 -> Empty stays 1 and requests underflow.
5. LoadString and LoadNextChar asserted together mid-stream -> no CharValid, pointer=0, next request returns char 0 of the new string.
6. Reset pulled low mid-rotation between clock edges -> outputs go to reset values without waiting for a clock edge. After release, requests underflow until a new LoadString.
